// File: rtl/conv_datapath_front_pkg.sv
// Shared types and constants for the convolution datapath front end.
// Coordinates are signed so that padding can push them below zero.
package conv_datapath_front_pkg;

  localparam int PIXELS_IN_ROW = 32;
  localparam int PIXEL_W       = 8;
  localparam int KROWS         = 3;
  localparam int COORD_W       = 18;
  localparam int ROW_W         = PIXELS_IN_ROW * PIXEL_W;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic [ROW_W-1:0]          row_t;

  typedef struct packed {
    logic [15:0] ox;
    logic [15:0] oy;
    logic [15:0] ix;
    logic [15:0] iy;
    logic [15:0] nif;
    logic [3:0]  k;
    logic [3:0]  s;
    logic [3:0]  p;
    logic [15:0] nif_in_2pow;
    logic [15:0] ix_in_2pow;
  } cfg_t;

endpackage

// File: rtl/conv_front_pixel_gen.sv
// Builds one kernel-row vector of 32 pixels from the synthetic feature-map
// model, forcing zero wherever the tap falls in padding or past the output.
module conv_front_pixel_gen
  import conv_datapath_front_pkg::*;
(
  input  logic [15:0] i_c,
  input  coord_t      i_y,
  input  coord_t      i_col_base,
  input  coord_t      i_s,
  input  coord_t      i_p,
  input  logic [15:0] i_ix,
  input  logic [15:0] i_iy,
  input  logic [15:0] i_ox,
  input  logic [15:0] i_ix_in_2pow,
  input  logic        i_row_en,
  output row_t        o_row
);

  coord_t      w_ix;
  coord_t      w_iy;
  coord_t      w_ox;
  logic        w_row_ok;
  logic [31:0] w_line_base;

  assign w_ix = coord_t'({2'b00, i_ix});
  assign w_iy = coord_t'({2'b00, i_iy});
  assign w_ox = coord_t'({2'b00, i_ox});

  assign w_row_ok = i_row_en && !i_y[COORD_W-1] && (i_y < w_iy);

  // Start address of input line y in channel c; only the low byte survives.
  assign w_line_base = ((i_c * i_iy) + 32'(i_y)) << i_ix_in_2pow;

  for (genvar j = 0; j < PIXELS_IN_ROW; j++) begin : g_pix
    coord_t              w_col;
    coord_t              w_x;
    logic                w_ok;
    logic [PIXEL_W-1:0]  w_val;

    assign w_col = i_col_base + coord_t'(j);
    assign w_x   = (w_col * i_s) - i_p;
    assign w_ok  = w_row_ok && !w_x[COORD_W-1] && (w_x < w_ix) && (w_col < w_ox);
    assign w_val = PIXEL_W'(w_line_base + 32'(w_x));

    assign o_row[j*PIXEL_W +: PIXEL_W] = w_ok ? w_val : '0;
  end

endmodule

// File: rtl/conv_datapath_front.sv
// Walks an output feature map (channel, x-tile, output row) after a start
// pulse and registers the three kernel-row pixel vectors for each step.
module conv_datapath_front
  import conv_datapath_front_pkg::*;
#(
  parameter int pixels_in_row         = PIXELS_IN_ROW,
  parameter int pixels_in_row_in_2pow = 5,
  parameter int buffers_num           = KROWS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [15:0]                  ox,
  input  logic [15:0]                  oy,
  input  logic [15:0]                  ix,
  input  logic [15:0]                  iy,
  input  logic [15:0]                  nif,
  input  logic [3:0]                   k,
  input  logic [3:0]                   s,
  input  logic [3:0]                   p,
  input  logic [15:0]                  nif_in_2pow,
  input  logic [15:0]                  ix_in_2pow,
  output logic [pixels_in_row*8-1:0]   re_row1_pixels,
  output logic [pixels_in_row*8-1:0]   re_row2_pixels,
  output logic [pixels_in_row*8-1:0]   re_row3_pixels
);

  state_t      r_state;
  state_t      w_state_next;
  cfg_t        r_cfg;
  cfg_t        w_cfg_in;
  logic [15:0] r_c;
  logic [15:0] r_t;
  logic [15:0] r_r;
  row_t        r_rows [buffers_num];
  row_t        w_rows [buffers_num];

  logic [15:0] w_c_mask;
  logic [15:0] w_c_inc;
  logic [16:0] w_tiles;
  logic        w_c_wrap;
  logic        w_t_wrap;
  logic        w_r_wrap;
  logic        w_last;

  assign w_cfg_in = '{ox: ox, oy: oy, ix: ix, iy: iy, nif: nif, k: k, s: s, p: p,
                      nif_in_2pow: nif_in_2pow, ix_in_2pow: ix_in_2pow};

  // Channel is innermost, then x-tile, then output row.
  assign w_c_mask = 16'((17'd1 << r_cfg.nif_in_2pow) - 17'd1);
  assign w_c_inc  = (r_c + 16'd1) & w_c_mask;
  assign w_c_wrap = (w_c_inc == 16'd0) || (r_c == r_cfg.nif - 16'd1);
  assign w_tiles  = (17'(r_cfg.ox) + 17'(pixels_in_row - 1)) >> pixels_in_row_in_2pow;
  assign w_t_wrap = (17'(r_t) + 17'd1) >= w_tiles;
  assign w_r_wrap = (17'(r_r) + 17'd1) >= 17'(r_cfg.oy);
  assign w_last   = w_c_wrap && w_t_wrap && w_r_wrap;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (en) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  coord_t w_s;
  coord_t w_p;
  coord_t w_col_base;
  coord_t w_ry;

  assign w_s        = coord_t'({14'd0, r_cfg.s});
  assign w_p        = coord_t'({14'd0, r_cfg.p});
  assign w_col_base = coord_t'({2'b00, r_t}) <<< pixels_in_row_in_2pow;
  assign w_ry       = (coord_t'({2'b00, r_r}) * w_s) - w_p;

  for (genvar m = 0; m < buffers_num; m++) begin : g_krow
    coord_t w_y;
    assign w_y = w_ry + coord_t'(m);

    conv_front_pixel_gen u_pix (
      .i_c          (r_c),
      .i_y          (w_y),
      .i_col_base   (w_col_base),
      .i_s          (w_s),
      .i_p          (w_p),
      .i_ix         (r_cfg.ix),
      .i_iy         (r_cfg.iy),
      .i_ox         (r_cfg.ox),
      .i_ix_in_2pow (r_cfg.ix_in_2pow),
      .i_row_en     (4'(m) < r_cfg.k),
      .o_row        (w_rows[m])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cfg   <= '0;
      r_c     <= '0;
      r_t     <= '0;
      r_r     <= '0;
      // NOTE: the row registers drive outputs that must read 0 after reset, so they are reset too.
      for (int m = 0; m < buffers_num; m++) r_rows[m] <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE) begin
        if (en) begin
          r_cfg <= w_cfg_in;
          r_c   <= '0;
          r_t   <= '0;
          r_r   <= '0;
        end
      end else begin
        for (int m = 0; m < buffers_num; m++) r_rows[m] <= w_rows[m];
        r_c <= w_c_wrap ? 16'd0 : w_c_inc;
        if (w_c_wrap) begin
          r_t <= w_t_wrap ? 16'd0 : r_t + 16'd1;
          if (w_t_wrap) r_r <= w_r_wrap ? 16'd0 : r_r + 16'd1;
        end
      end
    end
  end

  assign re_row1_pixels = r_rows[0];
  assign re_row2_pixels = r_rows[1];
  assign re_row3_pixels = r_rows[2];

endmodule

// File: tb/tb_conv_datapath_front.sv
// Directed bench for conv_datapath_front: hand-derived pixel ramps per step,
// covering padding, stride, channel order, output-column cut-off and abort.
module tb_conv_datapath_front;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [15:0]  ox, oy, ix, iy, nif, nif_in_2pow, ix_in_2pow;
  logic [3:0]   k, s, p;
  logic [255:0] row1, row2, row3;
  logic [255:0] zero = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_datapath_front dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .ox             (ox),
    .oy             (oy),
    .ix             (ix),
    .iy             (iy),
    .nif            (nif),
    .k              (k),
    .s              (s),
    .p              (p),
    .nif_in_2pow    (nif_in_2pow),
    .ix_in_2pow     (ix_in_2pow),
    .re_row1_pixels (row1),
    .re_row2_pixels (row2),
    .re_row3_pixels (row3)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pixel j = (base + stp*j) & 255 for lo <= j < hi, zero elsewhere.
  function automatic logic [255:0] ramp(input int base, input int stp, input int lo, input int hi);
    logic [255:0] v;
    v = '0;
    for (int j = 0; j < 32; j++)
      if (j >= lo && j < hi) v[j*8 +: 8] = 8'((base + stp * j) & 255);
    return v;
  endfunction

  task automatic set_cfg(input int ox_v, input int oy_v, input int ix_v, input int iy_v,
                         input int nif_v, input int n2_v, input int i2_v,
                         input int k_v, input int s_v, input int p_v);
    ox = 16'(ox_v); oy = 16'(oy_v); ix = 16'(ix_v); iy = 16'(iy_v);
    nif = 16'(nif_v); nif_in_2pow = 16'(n2_v); ix_in_2pow = 16'(i2_v);
    k = 4'(k_v); s = 4'(s_v); p = 4'(p_v);
  endtask

  task automatic pulse_en();
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    set_cfg(64, 64, 256, 256, 1, 0, 8, 1, 1, 0);
    #10;
    check("reset_row1", row1, zero);
    check("reset_row2", row2, zero);
    check("reset_row3", row3, zero);
    @(negedge clk) reset = 1'b0;
    repeat (4) step();
    check("idle_no_en", row1, zero);

    // Base walk: 2 tiles x 64 rows = 128 steps.
    pulse_en();
    step();
    check("base_s0_row1", row1, ramp(0, 1, 0, 32));
    check("base_s0_row2", row2, zero);
    check("base_s0_row3", row3, zero);
    step();
    check("base_s1_row1", row1, ramp(32, 1, 0, 32));
    step();
    check("base_s2_row1", row1, ramp(0, 1, 0, 32));
    repeat (125) step();
    check("base_s127_row1", row1, ramp(32, 1, 0, 32));
    repeat (5) step();
    check("base_hold", row1, ramp(32, 1, 0, 32));
    pulse_en();
    check("restart_hold", row1, ramp(32, 1, 0, 32));
    step();
    check("restart_s0", row1, ramp(0, 1, 0, 32));
    do_reset();

    // Padding p=1 with a 3-row kernel.
    set_cfg(64, 64, 256, 256, 1, 0, 8, 3, 1, 1);
    pulse_en();
    step();
    check("pad_row1", row1, zero);
    check("pad_row2", row2, ramp(-1, 1, 1, 32));
    check("pad_row3", row3, ramp(-1, 1, 1, 32));
    do_reset();

    // Stride 2.
    set_cfg(64, 64, 256, 256, 1, 0, 8, 1, 2, 0);
    pulse_en();
    step();
    check("stride_s0_row1", row1, ramp(0, 2, 0, 32));
    check("stride_s0_row2", row2, zero);
    step();
    check("stride_s1_row1", row1, ramp(64, 2, 0, 32));
    do_reset();

    // Two channels: channel steps before the tile.
    set_cfg(64, 64, 256, 256, 2, 1, 8, 1, 1, 0);
    pulse_en();
    step();
    check("chan_s0", row1, ramp(0, 1, 0, 32));
    step();
    check("chan_s1", row1, ramp(0, 1, 0, 32));
    step();
    check("chan_s2", row1, ramp(32, 1, 0, 32));
    do_reset();

    // Small map where the channel term reaches the low byte: (3<<4)=48.
    set_cfg(16, 1, 16, 3, 2, 1, 4, 1, 1, 0);
    pulse_en();
    step();
    check("small_c0", row1, ramp(0, 1, 0, 16));
    step();
    check("small_c1", row1, ramp(48, 1, 0, 16));
    repeat (3) step();
    check("small_hold", row1, ramp(48, 1, 0, 16));
    do_reset();

    // ox=40: second tile keeps only 8 columns; en mid-run ignored; reset aborts.
    set_cfg(40, 64, 256, 256, 1, 0, 8, 1, 1, 0);
    pulse_en();
    step();
    check("ox40_s0", row1, ramp(0, 1, 0, 32));
    step();
    check("ox40_s1", row1, ramp(32, 1, 0, 8));
    en = 1'b1;
    step();
    en = 1'b0;
    check("ox40_s2", row1, ramp(0, 1, 0, 32));
    step();
    check("ignored_en_s3", row1, ramp(32, 1, 0, 8));
    reset = 1'b1;
    #1;
    check("abort_row1", row1, zero);
    check("abort_row2", row2, zero);
    check("abort_row3", row3, zero);
    @(negedge clk) reset = 1'b0;
    repeat (3) step();
    check("abort_stays_idle", row1, zero);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_datapath_front.md
Name: conv_datapath_front

Overview:
Front end of the convolution datapath. A one-cycle start pulse makes it walk an output feature map autonomously. Each step, it presents the three kernel-row input pixel vectors (32 pixels × 8 bit) that the downstream MAC array consumes. Input pixels come from an internal deterministic feature-map model: a synthetic address-derived pattern with zero padding. This makes the block self-contained for bring-up and verification.

Parameters:
pixels_in_row, 32, pixels per output row vector
pixels_in_row_in_2pow, 5, log2(pixels_in_row)
buffers_num, 3, number of kernel-row vectors (fixed 3)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  start pulse, sampled in IDLE only
ox, oy  in  16 each  output width/height
ix, iy  in  16 each  input width/height
nif  in  16  input channel count
k, s, p  in  4 each  kernel size, stride, padding
nif_in_2pow  in  16  log2(nif)
ix_in_2pow  in  16  log2(ix); ix is a power of two
re_row1_pixels, re_row2_pixels, re_row3_pixels  out  pixels_in_row*8 each  kernel rows 0/1/2; pixel j at bits [8j+7:8j]

Behaviour:
- Reset: FSM=IDLE; all counters 0; all three outputs 0. Reset mid-run aborts immediately to this state.
- IDLE + en=1: latch all config inputs, clear counters, go RUN. Config changes after the start edge are ignored until the next start.
- In RUN, en is ignored.
- RUN: one step per clock. Outputs are registered, so step 0 appears on the first rising edge after the start edge (latency 1).
- Loop order, innermost first:
  - channel c = 0..nif-1
  - x-tile t = 0..ceil(ox/32)-1
  - output row r = 0..oy-1
- Channel wrap uses a mask of nif_in_2pow bits. Tile count is ox + 31 >> 5.
- After the last step (c=nif-1, last t, r=oy-1): return to IDLE. Outputs hold the last step's value.
- Per step, for kernel row m (0..2) and pixel j (0..31):
  - y = r*s − p + m
  - x = (t*32 + j)*s − p
  - Use signed 18-bit arithmetic.
- Pixel value = 0 if any of the following holds:
  - y<0 or y≥iy
  - x<0 or x≥ix
  - t*32+j ≥ ox (column beyond the output)
  - m ≥ k (row unused by the kernel; k=1 uses row1 only, k=2 rows1–2, k≥3 all three)
- Otherwise pixel = low 8 bits of ((c*iy + y) << ix_in_2pow) + x.
- All 32×3 pixels are computed combinationally from the counters and registered together.

Decomposition:
- Shared package holds:
  - constants PIXELS_IN_ROW=32, PIXEL_W=8, KROWS=3
  - FSM state enum {IDLE, RUN}
  - the signed coordinate width (18)
- One natural sub-module: conv_front_pixel_gen. It takes (c, y, x-base, s, p, bounds) and returns one 32-pixel row vector, and is instantiated three times. The top holds the FSM and loop counters.

Test Plan:
- Reset then hold: reset=1 for 10 ns -> all outputs 0, FSM IDLE; no activity without en.
- Base config: k=1,s=1,p=0,ox=oy=64,ix=iy=256,nif=1,nif_in_2pow=0,ix_in_2pow=8; one-cycle en. Required outputs:
  - cycle 1: row1 pixel j=j, rows2/3=0
  - cycle 2: row1 pixel j=32+j
  - cycle 3 (r=1): row1 pixel j=j
  - after 128 steps: IDLE, outputs hold
- Padding: k=3,s=1,p=1, same sizes, step 0:
  - row1 all 0
  - row2 pixel0=0, pixel j=j−1
  - row3 pixel0=0, pixel j=(256+j−1)&255 = j−1
- Stride: k=1,s=2,p=0, step 0 -> row1 pixel j=2j. Step 1 (t=1) -> pixel j=(64+2j)&255.
- Channels: nif=2,nif_in_2pow=1,iy=256 -> step 0 uses c=0, step 1 uses c=1 with the same tile. c=1 adds (256<<8), so low byte is unchanged: pixel j=j.
- Boundary/abort: ox=40 -> tile 1 pixels j≥8 are 0. A second en mid-run is ignored. Reset asserted mid-run -> outputs 0 immediately.
